// File: rtl/chan_mux_rr.sv
// chan_mux_rr: N-channel valid/ready mux with fixed-priority or round-robin arbitration into a one-entry output register.
// Packet locking (in_last/out_last) is compiled in when CHAN_MUX_LOCK_EN is defined.
module chan_mux_rr #(
    parameter int NCH = 4,
    parameter int DW  = 8,
    parameter int CW  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic [NCH-1:0]    in_valid,
    input  logic [NCH*DW-1:0] in_data,
`ifdef CHAN_MUX_LOCK_EN
    input  logic [NCH-1:0]    in_last,
    output logic              out_last,
`endif
    output logic [NCH-1:0]    in_ready,
    output logic              out_valid,
    output logic [DW-1:0]     out_data,
    output logic [CW-1:0]     out_chan,
    input  logic              out_ready
);

    if (CW != $clog2(NCH)) begin : g_bad_cw
        $error("chan_mux_rr: CW must equal $clog2(NCH)");
    end
    if (NCH < 2 || NCH > 16) begin : g_bad_nch
        $error("chan_mux_rr: NCH must be in 2..16");
    end

    logic [CW-1:0] ptr;
    logic [CW-1:0] gnt;
    logic [CW-1:0] idx;
    logic [DW-1:0] sel_data;
    logic          found;
    logic          can_load;
    logic          xfer;
    logic          last_beat;
    int            tmp;

`ifdef CHAN_MUX_LOCK_EN
    logic          lock;
    logic [CW-1:0] lock_chan;
    assign last_beat = in_last[gnt];
`else
    assign last_beat = 1'b1;
`endif

    // rst gates can_load so in_ready falls immediately on an asynchronous reset
    assign can_load = !rst && (!out_valid || out_ready);
    assign xfer     = found && can_load;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        tmp   = 0;
        for (int k = 0; k < NCH; k++) begin
            tmp = mode ? (int'(ptr) + k) % NCH : k;
            idx = CW'(tmp);
            if (!found && in_valid[idx]) begin
                gnt   = idx;
                found = 1'b1;
            end
        end
`ifdef CHAN_MUX_LOCK_EN
        if (lock) begin
            gnt   = lock_chan;
            found = in_valid[lock_chan];
        end
`endif
    end

    always_comb begin
        in_ready = '0;
        sel_data = '0;
        for (int k = 0; k < NCH; k++) begin
            in_ready[k] = xfer && (CW'(k) == gnt);
            if (CW'(k) == gnt) sel_data = in_data[k*DW +: DW];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            ptr       <= '0;
        end else begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= sel_data;
                out_chan  <= gnt;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (xfer && last_beat) ptr <= (gnt == CW'(NCH - 1)) ? '0 : gnt + 1'b1;
        end
    end

`ifdef CHAN_MUX_LOCK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock      <= 1'b0;
            lock_chan <= '0;
            out_last  <= 1'b0;
        end else if (xfer) begin
            lock      <= !in_last[gnt];
            lock_chan <= gnt;
            out_last  <= in_last[gnt];
        end
    end
`endif

endmodule

// File: tb/tb_chan_mux_rr.sv
// tb_chan_mux_rr: directed self-checking bench for chan_mux_rr (NCH=4, DW=8).
// Lock scenario runs only when CHAN_MUX_LOCK_EN is defined.
module tb_chan_mux_rr;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_chan;
    logic        out_ready;
`ifdef CHAN_MUX_LOCK_EN
    logic [3:0]  in_last;
    logic        out_last;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    chan_mux_rr #(.NCH(4), .DW(8), .CW(2)) dut (
        .clk(clk),
        .rst(rst),
        .mode(mode),
        .in_valid(in_valid),
        .in_data(in_data),
`ifdef CHAN_MUX_LOCK_EN
        .in_last(in_last),
        .out_last(out_last),
`endif
        .in_ready(in_ready),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_chan(out_chan),
        .out_ready(out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic [1:0] c);
        chk({tag, "_valid"}, 32'(out_valid), 32'(v));
        chk({tag, "_data"}, 32'(out_data), 32'(d));
        chk({tag, "_chan"}, 32'(out_chan), 32'(c));
    endtask

    initial begin
        rst       = 1'b1;
        mode      = 1'b0;
        in_valid  = 4'b0000;
        in_data   = 32'h44_33_22_11;
        out_ready = 1'b0;
`ifdef CHAN_MUX_LOCK_EN
        in_last   = 4'b1111;
`endif
        tick();
        tick();
        chk_out("reset", 1'b0, 8'h00, 2'd0);
        chk("reset_ready", 32'(in_ready), 32'h0);
        rst = 1'b0;
        tick();

        // fixed priority: ch1 always beats ch3
        mode      = 1'b0;
        in_valid  = 4'b1010;
        out_ready = 1'b1;
        #1;
        chk("fp_ready0", 32'(in_ready), 32'b0010);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_out("fp", 1'b1, 8'h22, 2'd1);
            chk("fp_ready", 32'(in_ready), 32'b0010);
        end
        in_valid = 4'b0000;
        tick();
        chk("fp_pop_valid", 32'(out_valid), 32'h0);
        chk("fp_pop_hold_data", 32'(out_data), 32'h22);

        // mode switch: ch1 in mode 0 leaves ptr=2, so mode 1 picks ch3
        in_valid = 4'b0010;
        tick();
        chk_out("ms_ch1", 1'b1, 8'h22, 2'd1);
        mode     = 1'b1;
        in_valid = 4'b1011;
        #1;
        chk("ms_ready", 32'(in_ready), 32'b1000);
        tick();
        chk_out("ms_ch3", 1'b1, 8'h44, 2'd3);
        in_valid = 4'b0000;
        tick();
        chk("ms_pop_valid", 32'(out_valid), 32'h0);

        // back-pressure: ch2 beat A5 held for 3 stalled cycles
        mode      = 1'b0;
        in_data   = 32'h44_A5_22_11;
        in_valid  = 4'b0100;
        out_ready = 1'b0;
        #1;
        chk("bp_ready_load", 32'(in_ready), 32'b0100);
        tick();
        chk_out("bp_load", 1'b1, 8'hA5, 2'd2);
        in_valid = 4'b0001;
        in_data  = 32'h44_A5_22_5A;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("bp_stall", 1'b1, 8'hA5, 2'd2);
            chk("bp_stall_ready", 32'(in_ready), 32'h0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(in_ready), 32'b0001);
        tick();
        chk_out("bp_nobubble", 1'b1, 8'h5A, 2'd0);

        // asynchronous reset mid-stall
        out_ready = 1'b0;
        #1;
        chk("rs_stall_ready", 32'(in_ready), 32'h0);
        rst = 1'b1;
        #1;
        chk_out("rs_async", 1'b0, 8'h00, 2'd0);
        chk("rs_ready", 32'(in_ready), 32'h0);
        tick();
        rst = 1'b0;

        // round robin from ptr=0 with all channels valid, one beat per cycle
        mode      = 1'b1;
        in_valid  = 4'b1111;
        in_data   = 32'h44_33_22_11;
        out_ready = 1'b1;
        #1;
        chk("rr_first_ready", 32'(in_ready), 32'b0001);
        tick();
        chk_out("rr0", 1'b1, 8'h11, 2'd0);
        tick();
        chk_out("rr1", 1'b1, 8'h22, 2'd1);
        tick();
        chk_out("rr2", 1'b1, 8'h33, 2'd2);
        tick();
        chk_out("rr3", 1'b1, 8'h44, 2'd3);
        tick();
        chk_out("rr_wrap", 1'b1, 8'h11, 2'd0);

`ifdef CHAN_MUX_LOCK_EN
        // ptr=1: ch1 sends a 3-beat packet while ch0 stays valid
        in_valid = 4'b0011;
        in_last  = 4'b1101;
        tick();
        chk_out("lk_b0", 1'b1, 8'h22, 2'd1);
        chk("lk_b0_last", 32'(out_last), 32'h0);
        mode = 1'b0;
        #1;
        chk("lk_forced_ready", 32'(in_ready), 32'b0010);
        tick();
        chk_out("lk_b1", 1'b1, 8'h22, 2'd1);
        chk("lk_b1_last", 32'(out_last), 32'h0);
        in_last = 4'b1111;
        tick();
        chk_out("lk_b2", 1'b1, 8'h22, 2'd1);
        chk("lk_b2_last", 32'(out_last), 32'h1);
        in_valid = 4'b0001;
        tick();
        chk_out("lk_after", 1'b1, 8'h11, 2'd0);
        chk("lk_after_last", 32'(out_last), 32'h1);
`endif

        in_valid = 4'b0000;
        tick();
        chk("end_pop_valid", 32'(out_valid), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/chan_mux_rr.md
Name: chan_mux_rr

Overview:
Parametrised N-channel, W-bit data multiplexer with valid/ready handshake on every input channel and on the output. Each cycle it arbitrates among the valid input channels using either fixed-priority or round-robin mode. The winning beat is registered into a single-entry output stage, tagged with its source channel index. It sits between several producer blocks and one shared downstream consumer, and generalises the fixed 4:1 selectors to arbitrated, flow-controlled channel merging.

Parameters:
NCH, 4, number of input channels (2..16)
DW, 8, data width per channel in bits
CW, 2, channel index width; must equal $clog2(NCH); elaboration error otherwise

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
mode  input  1  0 = fixed priority (lowest index wins), 1 = round robin
in_valid  input  NCH  per-channel beat valid
in_data  input  NCH*DW  channel i data occupies bits [i*DW +: DW]
in_ready  output  NCH  per-channel accept; at most one bit high per cycle
out_valid  output  1  output register holds a beat
out_data  output  DW  registered data of held beat
out_chan  output  CW  source channel index of held beat
out_ready  input  1  downstream accepts beat when out_valid=1

Behaviour:
- Reset: rst=1 asynchronously clears out_valid=0, out_data=0, out_chan=0, rr pointer ptr=0 (and lock state, if compiled).
- can_load = !out_valid || out_ready. Combinational path from out_ready to in_ready is intentional.
- Grant is combinational from in_valid, mode and ptr.
  - mode=0: grant = lowest index i with in_valid[i]=1.
  - mode=1: grant = first valid index searching ptr, ptr+1, ... wrapping modulo NCH.
- in_ready[g] = can_load for the granted channel g; all other in_ready bits are 0. If no channel is valid, in_ready is all zeros.
- Transfer on channel g when in_valid[g] && in_ready[g]. On the next edge: out_data <= in_data[g], out_chan <= g, out_valid <= 1.
- Output pop with no new transfer (out_valid && out_ready): out_valid <= 0. out_data and out_chan hold their last values.
- Simultaneous pop and transfer in the same cycle: new beat loaded and out_valid stays 1. This gives 1 beat/cycle throughput.
- Latency: 1 cycle from input transfer to out_valid.
- Pointer update: after any transfer from channel g, ptr <= (g+1) mod NCH, including g=NCH-1 wrapping to 0. The pointer updates in both modes, so a switch to mode=1 resumes fairly.
- mode is sampled combinationally each cycle. A change affects the next grant only; the held beat is unaffected.
- Stall (out_valid=1, out_ready=0): in_ready all 0, and out_data/out_chan are stable.
- Producers must hold in_valid and in_data until accepted. A channel whose in_valid drops without acceptance loses nothing and simply stops being considered.
- Reset mid-operation: the held beat is discarded and in_ready drops to 0 immediately.

Optional Feature:
Macro CHAN_MUX_LOCK_EN enables packet locking.
- Defined:
  - Adds input in_last [NCH] and output out_last [1]; out_last is registered alongside out_data and reset to 0.
  - Accepting a beat from g with in_last[g]=0 sets lock=1, lock_chan=g.
  - While lock=1, the grant is forced to lock_chan regardless of mode or other valids. If lock_chan is not valid, in_ready is all zero.
  - Accepting a beat with in_last=1 clears lock.
  - ptr updates only on in_last=1 beats.
  - Reset clears lock.
- Undefined: in_last and out_last are absent, and every beat is arbitrated independently.

Test Plan:
1. Reset: assert rst mid-stall with out_valid=1 -> out_valid=0, out_data=0, out_chan=0, in_ready=0 immediately; after release, the first grant in mode=1 goes to ch0.
2. Fixed priority: mode=0, NCH=4, in_valid=4'b1010, out_ready=1 for 4 cycles -> out_chan sequence 1,1,1,1; ch3 never granted while ch1 stays valid.
3. Round robin: mode=1, in_valid=4'b1111 held, out_ready=1 -> out_chan 0,1,2,3,0; the wrap from 3 to 0 is checked; one beat per cycle.
4. Back-pressure: hold out_ready=0 for 3 cycles with beat 0xA5 from ch2 -> out_data=0xA5 and out_chan=2 stable, in_ready=0. Then out_ready=1 with ch0 valid -> next cycle out_data=ch0 data, with no bubble.
5. Mode switch: after ch1 is accepted in mode=0 with in_valid=4'b1011, switch to mode=1 -> next grant is ch3 (ptr=2, search 2,3).
6. Lock (CHAN_MUX_LOCK_EN): ch1 sends 3 beats, last on the third, while ch0 stays valid -> out_chan=1,1,1, then 0; out_last=1 only on the third beat.
